piso_stream: RTL and testbench
==============================

Name: piso_stream

Overview:
Parametrised parallel-in/serial-out converter with valid/ready handshakes on both sides.
- Accepts a WIDTH-bit word on the load side and emits it one bit per accepted beat on the serial side.
- Bit order is selectable (LSB-first or MSB-first). The last bit is flagged.
- Supports downstream backpressure and back-to-back words with no bubble.
- Sits between a word-wide datapath and a bit-serial link or serializer front end.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 0, 0 = emit p_in[0] first; 1 = emit p_in[WIDTH-1] first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- p_in  input  WIDTH  parallel word. Sampled only on a load handshake.
- load_valid  input  1  upstream has a word on p_in.
- load_ready  output  1  block can accept a word this cycle.
- s_out  output  1  current serial bit.
- s_valid  output  1  s_out holds a valid bit.
- s_last  output  1  current bit is the final bit of the word.
- s_ready  input  1  downstream accepts s_out this cycle.
- empty  output  1  no word is held; block is idle.

Behaviour:
- Reset: when rst is asserted, these values take effect immediately, independent of clk.
  - State IDLE; shift register = 0; bit counter = 0.
  - s_out = 0, s_valid = 0, s_last = 0, empty = 1, load_ready = 1.
- Bit counter width is $clog2(WIDTH). It counts 0..WIDTH-1 and never wraps past WIDTH-1.
- Load handshake occurs when load_valid && load_ready at a rising edge.
- Serial beat occurs when s_valid && s_ready at a rising edge.
- States: IDLE and SHIFT.
- IDLE:
  - Outputs: s_valid = 0, s_last = 0, empty = 1, load_ready = 1. s_out holds its last value (0 after reset).
  - On a load handshake: capture p_in into the shift register, set counter = 0, go to SHIFT.
  - First bit appears on s_out with s_valid = 1 in the next cycle, i.e. 1-cycle load-to-first-bit latency.
- SHIFT:
  - Outputs: s_valid = 1, empty = 0.
  - s_out = shreg[0] when MSB_FIRST = 0; s_out = shreg[WIDTH-1] when MSB_FIRST = 1. s_out is a direct register bit, with no logic from inputs.
  - s_last = 1 exactly when counter == WIDTH-1.
  - s_ready = 0: shift register, counter and all outputs hold. s_out stays stable while s_valid && !s_ready.
  - Beat with counter < WIDTH-1: shift toward the output end (right for LSB-first, left for MSB-first), fill with 0, counter += 1.
  - Beat with counter == WIDTH-1:
    - with a simultaneous load handshake: capture new p_in, counter = 0, stay in SHIFT. No idle cycle between words.
    - without a load handshake: go to IDLE, counter = 0.
- load_ready = (state == IDLE) || (state == SHIFT && counter == WIDTH-1 && s_ready).
  - This is the only combinational input-to-output path (s_ready -> load_ready).
- load_valid while in SHIFT and not on the last beat: ignored. p_in is not sampled, and upstream must hold its word.
- p_in changes outside a load handshake have no effect.
- Exactly WIDTH beats are produced per accepted word, and bits are never duplicated or dropped under any s_ready pattern.
- Reset mid-word: the partial word is discarded, outputs return to reset values, and no further bits of that word are emitted after rst deasserts.

Test Plan:
1. WIDTH=8, MSB_FIRST=0, s_ready=1, load p_in=8'hA5.
   -> s_out sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after load.
   -> s_last high only on the 8th bit; empty = 1 the cycle after.
2. Same word with MSB_FIRST=1.
   -> sequence 1,0,1,0,0,1,0,1, with s_last on the bit taken from p_in[0].
   Then p_in=8'h0F -> 0,0,0,0,1,1,1,1.
3. Backpressure, WIDTH=8, MSB_FIRST=0, p_in=8'hA5, s_ready toggling 1,0,0,1,...
   -> s_out and s_last hold during s_ready=0.
   -> still exactly 8 accepted beats with the values from scenario 1; load_ready stays 0 until the last beat.
4. Back-to-back, load_valid held high with words 8'h3C then 8'hC3, s_ready=1.
   -> 16 contiguous valid beats with no s_valid gap.
   -> load_ready pulses on beat 8; s_last on beats 8 and 16.
5. Assert rst asynchronously mid-word, after 3 bits of 8'hFF.
   -> s_valid, s_out and s_last go to 0 and empty to 1 immediately, without a clock edge.
   -> after release, no residual bits; a new load of 8'h01 emits 1,0,0,0,0,0,0,0.
6. WIDTH=2 corner, MSB_FIRST=0, p_in=2'b10, s_ready=1, with a second load 2'b01 offered on the last beat.
   -> output 0,1,1,0; s_last on beats 2 and 4; counter never exceeds 1.

Source files
------------

// File: rtl/piso_stream_if.sv
// Handshake bundle for piso_stream: word load side plus bit-serial output side.
interface piso_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] p_in;
  logic             load_valid;
  logic             load_ready;
  logic             s_out;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic             empty;

  modport master (
    output p_in, load_valid, s_ready,
    input  load_ready, s_out, s_valid, s_last, empty
  );

  modport slave (
    input  p_in, load_valid, s_ready,
    output load_ready, s_out, s_valid, s_last, empty
  );
endinterface

// File: rtl/piso_stream.sv
// Parallel-in/serial-out converter: one WIDTH-bit word in, WIDTH serial beats out,
// with a load accepted on the final beat so consecutive words stream without a bubble.
module piso_stream #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  piso_stream_if.slave  bus
);
  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [0:0]      ST_IDLE  = 1'b0;
  localparam logic [0:0]      ST_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_valid;
  logic             r_last;
  logic             r_empty;

  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic             w_at_last;
  logic             w_beat;
  logic             w_load_ready;
  logic             w_load;

  assign w_at_last    = (r_cnt == LAST_IDX);
  assign w_beat       = (r_state == ST_SHIFT) && bus.s_ready;
  assign w_load_ready = (r_state == ST_IDLE) || (w_beat && w_at_last);
  assign w_load       = bus.load_valid && w_load_ready;
  // Move the next bit into the output position, filling the vacated end with zero.
  assign w_shifted    = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};

  // Next-state decode for state, shift register and bit counter.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_state_nxt = ST_SHIFT;
          w_shreg_nxt = bus.p_in;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!w_beat) begin
          w_state_nxt = ST_SHIFT;
        end else if (!w_at_last) begin
          w_shreg_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end else if (w_load) begin
          w_shreg_nxt = bus.p_in;
          w_cnt_nxt   = '0;
        end else begin
          // Shift register is left untouched so s_out keeps the last bit while idle.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_shreg_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers; outputs are precomputed from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_state_nxt == ST_SHIFT);
      r_last  <= (w_state_nxt == ST_SHIFT) && (w_cnt_nxt == LAST_IDX);
      r_empty <= (w_state_nxt == ST_IDLE);
    end
  end

  assign bus.load_ready = w_load_ready;
  assign bus.s_out      = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign bus.s_valid    = r_valid;
  assign bus.s_last     = r_last;
  assign bus.empty      = r_empty;
endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: three instances (8-bit LSB-first, 8-bit MSB-first, 2-bit)
// checked against a queue-of-expected-bits model of the stream.
module tb_piso_stream;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  piso_stream_if #(.WIDTH(8)) bus_l ();
  piso_stream_if #(.WIDTH(8)) bus_m ();
  piso_stream_if #(.WIDTH(2)) bus_2 ();

  piso_stream #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bus_l.slave));
  piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bus_m.slave));
  piso_stream #(.WIDTH(2), .MSB_FIRST(1'b0)) u_w2  (.clk(clk), .rst(rst), .bus(bus_2.slave));

  int         sel = 0;
  logic [7:0] d_p_in = 8'h00;
  logic       d_lv = 1'b0;
  logic       d_sr = 1'b0;

  assign bus_l.p_in       = d_p_in;
  assign bus_m.p_in       = d_p_in;
  assign bus_2.p_in       = d_p_in[1:0];
  assign bus_l.load_valid = d_lv && (sel == 0);
  assign bus_m.load_valid = d_lv && (sel == 1);
  assign bus_2.load_valid = d_lv && (sel == 2);
  assign bus_l.s_ready    = d_sr;
  assign bus_m.s_ready    = d_sr;
  assign bus_2.s_ready    = d_sr;

  logic v_out, v_valid, v_last, v_empty, v_lr;
  always_comb begin
    v_out = 1'b0; v_valid = 1'b0; v_last = 1'b0; v_empty = 1'b0; v_lr = 1'b0;
    case (sel)
      0: begin v_out = bus_l.s_out; v_valid = bus_l.s_valid; v_last = bus_l.s_last; v_empty = bus_l.empty; v_lr = bus_l.load_ready; end
      1: begin v_out = bus_m.s_out; v_valid = bus_m.s_valid; v_last = bus_m.s_last; v_empty = bus_m.empty; v_lr = bus_m.load_ready; end
      default: begin v_out = bus_2.s_out; v_valid = bus_2.s_valid; v_last = bus_2.s_last; v_empty = bus_2.empty; v_lr = bus_2.load_ready; end
    endcase
  end

  int         vecs = 0;
  int         errs = 0;
  logic [7:0] words[$];
  bit         obs[$];
  int         g_first, g_last;

  // Present queued words upstream, drive s_ready per rmode, and check every cycle
  // against a model that only tracks the bits still owed downstream.
  task automatic run_stream(input int s, input int rmode, input int vmode, input int budget);
    int         w;
    bit         msb;
    bit         q[$];
    int         idx;
    int         cyc;
    bit         have;
    logic [7:0] cur;
    logic       exp_lr;
    logic       seen;
    w = (s == 2) ? 2 : 8;
    msb = (s == 1);
    idx = 0; cyc = 0; have = 1'b0; cur = 8'h00;
    g_first = -1; g_last = -1;
    obs.delete();
    sel = s;
    while (cyc < budget && (idx < words.size() || have || q.size() != 0)) begin
      @(negedge clk);
      if (!have && idx < words.size()) begin
        cur = words[idx]; idx++; have = 1'b1;
      end
      d_p_in = have ? cur : 8'($urandom_range(0, 255));
      d_lv = have && (vmode == 0 || $urandom_range(0, 2) != 0);
      case (rmode)
        0: d_sr = 1'b1;
        1: d_sr = 1'($urandom_range(0, 1));
        default: d_sr = (cyc % 3 == 0);
      endcase
      exp_lr = (q.size() == 0) || (q.size() == 1 && d_sr);
      #1;
      vecs++;
      if (v_valid !== (q.size() != 0)) begin errs++; $display("FAIL s_valid sel=%0d cyc=%0d got=%b exp=%b", s, cyc, v_valid, q.size() != 0); end
      vecs++;
      if (v_empty !== (q.size() == 0)) begin errs++; $display("FAIL empty sel=%0d cyc=%0d got=%b exp=%b", s, cyc, v_empty, q.size() == 0); end
      vecs++;
      if (v_last !== (q.size() == 1)) begin errs++; $display("FAIL s_last sel=%0d cyc=%0d got=%b exp=%b", s, cyc, v_last, q.size() == 1); end
      vecs++;
      if (v_lr !== exp_lr) begin errs++; $display("FAIL load_ready sel=%0d cyc=%0d got=%b exp=%b", s, cyc, v_lr, exp_lr); end
      if (q.size() != 0) begin
        vecs++;
        if (v_out !== q[0]) begin errs++; $display("FAIL s_out sel=%0d cyc=%0d got=%b exp=%b", s, cyc, v_out, q[0]); end
      end
      seen = v_out;
      @(posedge clk);
      if (q.size() != 0 && d_sr) begin
        void'(q.pop_front());
        obs.push_back(seen);
        if (g_first < 0) g_first = cyc;
        g_last = cyc;
      end
      if (d_lv && exp_lr) begin
        for (int i = 0; i < w; i++) q.push_back(msb ? cur[w-1-i] : cur[i]);
        have = 1'b0;
      end
      cyc++;
    end
    @(negedge clk);
    d_lv = 1'b0;
    vecs++;
    if (idx < words.size() || have || q.size() != 0) begin
      errs++; $display("FAIL timeout sel=%0d words_left=%0d bits_left=%0d exp=0", s, words.size() - idx, q.size());
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      vecs++;
      if ({v_valid, v_out, v_last, v_empty, v_lr} !== 5'b00011) begin
        errs++; $display("FAIL reset_state sel=%0d got=%b exp=00011", s, {v_valid, v_out, v_last, v_empty, v_lr});
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lsb_first();
    logic [7:0] got;
    words = '{8'hA5};
    run_stream(0, 0, 0, 40);
    got = 8'h00;
    for (int i = 0; i < obs.size() && i < 8; i++) got[i] = obs[i];
    vecs++;
    if (obs.size() != 8 || got !== 8'hA5) begin errs++; $display("FAIL lsb_a5 got=%h n=%0d exp=a5 n=8", got, obs.size()); end
    vecs++;
    if (g_last - g_first != 7) begin errs++; $display("FAIL lsb_contig span=%0d exp=7", g_last - g_first); end
    words.delete();
    for (int i = 0; i < 6; i++) words.push_back(8'($urandom_range(0, 255)));
    run_stream(0, 1, 1, 400);
  endtask

  task automatic test_msb_first();
    logic [7:0] got;
    words = '{8'hA5};
    run_stream(1, 0, 0, 40);
    got = 8'h00;
    for (int i = 0; i < obs.size() && i < 8; i++) got[7-i] = obs[i];
    vecs++;
    if (obs.size() != 8 || got !== 8'hA5) begin errs++; $display("FAIL msb_a5 got=%h n=%0d exp=a5 n=8", got, obs.size()); end
    words = '{8'h0F};
    run_stream(1, 0, 0, 40);
    got = 8'h00;
    for (int i = 0; i < obs.size() && i < 8; i++) got[7-i] = obs[i];
    vecs++;
    if (obs.size() != 8 || got !== 8'h0F) begin errs++; $display("FAIL msb_0f got=%h n=%0d exp=0f n=8", got, obs.size()); end
    words.delete();
    for (int i = 0; i < 6; i++) words.push_back(8'($urandom_range(0, 255)));
    run_stream(1, 1, 1, 400);
  endtask

  task automatic test_backpressure();
    logic [7:0] got;
    words = '{8'hA5};
    run_stream(0, 2, 0, 80);
    got = 8'h00;
    for (int i = 0; i < obs.size() && i < 8; i++) got[i] = obs[i];
    vecs++;
    if (obs.size() != 8 || got !== 8'hA5) begin errs++; $display("FAIL bp_a5 got=%h n=%0d exp=a5 n=8", got, obs.size()); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got;
    words = '{8'h3C, 8'hC3};
    run_stream(0, 0, 0, 60);
    got = 16'h0000;
    for (int i = 0; i < obs.size() && i < 16; i++) got[i] = obs[i];
    vecs++;
    if (obs.size() != 16 || got !== 16'hC33C) begin errs++; $display("FAIL b2b_bits got=%h n=%0d exp=c33c n=16", got, obs.size()); end
    vecs++;
    if (g_last - g_first != 15) begin errs++; $display("FAIL b2b_contig span=%0d exp=15", g_last - g_first); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] got;
    sel = 0;
    @(negedge clk);
    d_p_in = 8'hFF; d_lv = 1'b1; d_sr = 1'b1;
    @(negedge clk);
    d_lv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    d_sr = 1'b0;
    #1;
    vecs++;
    if ({v_valid, v_out, v_empty} !== 3'b110) begin errs++; $display("FAIL pre_reset got=%b exp=110", {v_valid, v_out, v_empty}); end
    #1 rst = 1'b1;
    #1;
    vecs++;
    if ({v_valid, v_out, v_last, v_empty, v_lr} !== 5'b00011) begin
      errs++; $display("FAIL async_reset got=%b exp=00011", {v_valid, v_out, v_last, v_empty, v_lr});
    end
    @(negedge clk);
    rst = 1'b0; d_sr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      vecs++;
      if (v_valid !== 1'b0 || v_empty !== 1'b1) begin errs++; $display("FAIL residual cyc=%0d valid=%b empty=%b exp=0/1", i, v_valid, v_empty); end
    end
    words = '{8'h01};
    run_stream(0, 0, 0, 40);
    got = 8'h00;
    for (int i = 0; i < obs.size() && i < 8; i++) got[i] = obs[i];
    vecs++;
    if (obs.size() != 8 || got !== 8'h01) begin errs++; $display("FAIL post_reset got=%h n=%0d exp=01 n=8", got, obs.size()); end
  endtask

  task automatic test_width2();
    logic [3:0] got;
    words = '{8'h02, 8'h01};
    run_stream(2, 0, 0, 30);
    got = 4'h0;
    for (int i = 0; i < obs.size() && i < 4; i++) got[i] = obs[i];
    vecs++;
    if (obs.size() != 4 || got !== 4'b0110) begin errs++; $display("FAIL w2_bits got=%b n=%0d exp=0110 n=4", got, obs.size()); end
    vecs++;
    if (g_last - g_first != 3) begin errs++; $display("FAIL w2_contig span=%0d exp=3", g_last - g_first); end
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back(8'($urandom_range(0, 3)));
    run_stream(2, 1, 1, 300);
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_width2();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
